// File: rtl/sky130_fd_io__gpiovrefv2_pkg.sv
// Shared types and defaults for the GPIO vref latch sequencing controller.
package sky130_fd_io__gpiovrefv2_pkg;

  localparam int CNT_W = 16;

  localparam int unsigned DEFAULT_SETUP_CYC   = 2;
  localparam int unsigned DEFAULT_HOLD_CYC    = 2;
  localparam int unsigned DEFAULT_STARTUP_CYC = 1200;

  typedef enum logic [2:0] {
    IDLE,
    OPEN,
    CLOSE,
    SETTLE,
    DONE
  } state_t;

endpackage

// File: rtl/sky130_fd_io__gpiovrefv2_rr_arb.sv
// Two-requester round-robin arbiter; the pointer moves off the winner on every grant.
module sky130_fd_io__gpiovrefv2_rr_arb (
  input  logic       clk,
  input  logic       reset_b,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant,
  output logic       grant_idx
);

  logic ptr;

  // Contention resolves by pointer only; a lone requester always wins.
  always_comb begin
    grant_idx = 1'b0;
    if (req == 2'b11) begin
      grant_idx = ptr;
    end else if (req[1]) begin
      grant_idx = 1'b1;
    end
    grant = 2'b00;
    if (req != 2'b00) begin
      grant = grant_idx ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      ptr <= 1'b0;
    end else if (update) begin
      ptr <= ~grant_idx;
    end
  end

endmodule

// File: rtl/sky130_fd_io__gpiovrefv2_ctrl.sv
// Sequences ref_sel/vrefgen_en into the vref cell latch (open, close, optional settle)
// on behalf of two requesters, with abort on enable_h loss.
module sky130_fd_io__gpiovrefv2_ctrl
  import sky130_fd_io__gpiovrefv2_pkg::*;
#(
  parameter int unsigned SETUP_CYC   = DEFAULT_SETUP_CYC,
  parameter int unsigned HOLD_CYC    = DEFAULT_HOLD_CYC,
  parameter int unsigned STARTUP_CYC = DEFAULT_STARTUP_CYC
) (
  input  logic       clk,
  input  logic       reset_b,
  input  logic       enable_h,
  input  logic [1:0] req,
  input  logic [9:0] req_ref_sel,
  input  logic [1:0] req_vref_en,
  output logic [1:0] ack,
  output logic [4:0] ref_sel,
  output logic       vrefgen_en,
  output logic       hld_h_n,
  output logic       busy,
  output logic       vref_ready,
  output logic       err
);

  localparam logic [CNT_W-1:0] SETUP_LD   = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD    = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] STARTUP_LD = CNT_W'(STARTUP_CYC - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       gnt_q;
  logic [4:0]       lat_ref_sel;
  logic             lat_vref_en;

  logic [1:0] grant;
  logic       grant_idx;
  logic       grant_take;
  logic [4:0] gnt_ref_sel;
  logic       gnt_vref_en;
  logic       settle_needed;

  assign grant_take    = (state == IDLE) && enable_h && (req != 2'b00);
  assign gnt_ref_sel   = grant_idx ? req_ref_sel[9:5] : req_ref_sel[4:0];
  assign gnt_vref_en   = req_vref_en[grant_idx];
  // The generator only needs time to settle when it is newly on or retargeted.
  assign settle_needed = vrefgen_en && (!lat_vref_en || (ref_sel != lat_ref_sel));

  sky130_fd_io__gpiovrefv2_rr_arb u_arb (
    .clk       (clk),
    .reset_b   (reset_b),
    .req       (req),
    .update    (grant_take),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      state       <= IDLE;
      cnt         <= '0;
      gnt_q       <= 2'b00;
      lat_ref_sel <= '0;
      lat_vref_en <= 1'b0;
      ack         <= 2'b00;
      ref_sel     <= '0;
      vrefgen_en  <= 1'b0;
      hld_h_n     <= 1'b0;
      busy        <= 1'b0;
      vref_ready  <= 1'b0;
      err         <= 1'b0;
    end else begin
      ack <= 2'b00;
      err <= 1'b0;
      // Losing enable_h clears the cell latch, so the history is forgotten and the
      // still-pending request will re-run with a full settle.
      if ((state != IDLE) && !enable_h) begin
        state       <= IDLE;
        err         <= 1'b1;
        hld_h_n     <= 1'b0;
        vref_ready  <= 1'b0;
        busy        <= 1'b0;
        lat_ref_sel <= '0;
        lat_vref_en <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (grant_take) begin
              state      <= OPEN;
              ref_sel    <= gnt_ref_sel;
              vrefgen_en <= gnt_vref_en;
              gnt_q      <= grant;
              hld_h_n    <= 1'b1;
              vref_ready <= 1'b0;
              busy       <= 1'b1;
              cnt        <= SETUP_LD;
            end
          end
          OPEN: begin
            if (cnt == '0) begin
              state   <= CLOSE;
              hld_h_n <= 1'b0;
              cnt     <= HOLD_LD;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          CLOSE: begin
            if (cnt == '0) begin
              if (settle_needed) begin
                state <= SETTLE;
                cnt   <= STARTUP_LD;
              end else begin
                state       <= DONE;
                ack         <= gnt_q;
                vref_ready  <= vrefgen_en;
                lat_ref_sel <= ref_sel;
                lat_vref_en <= vrefgen_en;
              end
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          SETTLE: begin
            if (cnt == '0) begin
              state       <= DONE;
              ack         <= gnt_q;
              vref_ready  <= vrefgen_en;
              lat_ref_sel <= ref_sel;
              lat_vref_en <= vrefgen_en;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sky130_fd_io__gpiovrefv2_ctrl.sv
// Directed bench for the vref latch controller; periods are counted from the grant edge.
module tb_sky130_fd_io__gpiovrefv2_ctrl;

  logic       clk = 1'b0;
  logic       reset_b;
  logic       enable_h;
  logic [1:0] req;
  logic [9:0] req_ref_sel;
  logic [1:0] req_vref_en;
  logic [1:0] ack;
  logic [4:0] ref_sel;
  logic       vrefgen_en;
  logic       hld_h_n;
  logic       busy;
  logic       vref_ready;
  logic       err;

  int total  = 0;
  int bad    = 0;
  int period = 0;
  int at;

  always #5 clk = ~clk;

  sky130_fd_io__gpiovrefv2_ctrl dut (
    .clk         (clk),
    .reset_b     (reset_b),
    .enable_h    (enable_h),
    .req         (req),
    .req_ref_sel (req_ref_sel),
    .req_vref_en (req_vref_en),
    .ack         (ack),
    .ref_sel     (ref_sel),
    .vrefgen_en  (vrefgen_en),
    .hld_h_n     (hld_h_n),
    .busy        (busy),
    .vref_ready  (vref_ready),
    .err         (err)
  );

  task automatic applyStimulus(input logic rst_b, input logic en_h, input logic [1:0] r,
                               input logic [4:0] rs0, input logic [4:0] rs1,
                               input logic [1:0] ven);
    reset_b     = rst_b;
    enable_h    = en_h;
    req         = r;
    req_ref_sel = {rs1, rs0};
    req_vref_en = ven;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance one cycle and land mid-period, away from the sampling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    period++;
  endtask

  task automatic wait_ack(input logic [1:0] mask, input int limit, output int hit);
    hit = -1;
    for (int i = 0; i < limit; i++) begin
      tick();
      if ((ack & mask) != 2'b00) begin
        hit = period;
        break;
      end
    end
  endtask

  initial begin
    applyStimulus(1'b0, 1'b1, 2'b00, 5'h00, 5'h00, 2'b00);
    tick();
    tick();
    checkOutput("rst_hld", hld_h_n, 1'b0);
    checkOutput("rst_ref_sel", ref_sel, 5'h00);
    checkOutput("rst_vrefgen_en", vrefgen_en, 1'b0);
    checkOutput("rst_ack", ack, 2'b00);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_vref_ready", vref_ready, 1'b0);
    checkOutput("rst_err", err, 1'b0);

    $display("[TB] first request from reset, settle expected");
    applyStimulus(1'b1, 1'b1, 2'b01, 5'h0A, 5'h00, 2'b01);
    period = 0;
    tick();
    checkOutput("s1_p1_hld", hld_h_n, 1'b1);
    checkOutput("s1_p1_busy", busy, 1'b1);
    checkOutput("s1_p1_ref_sel", ref_sel, 5'h0A);
    checkOutput("s1_p1_vrefgen_en", vrefgen_en, 1'b1);
    checkOutput("s1_p1_vref_ready", vref_ready, 1'b0);
    applyStimulus(1'b1, 1'b1, 2'b00, 5'h0A, 5'h00, 2'b01);
    tick();
    checkOutput("s1_p2_hld", hld_h_n, 1'b1);
    tick();
    checkOutput("s1_p3_hld", hld_h_n, 1'b0);
    tick();
    checkOutput("s1_p4_hld", hld_h_n, 1'b0);
    checkOutput("s1_p4_ack", ack, 2'b00);
    wait_ack(2'b11, 1300, at);
    checkOutput("s1_ack_period", at, 1205);
    checkOutput("s1_ack_val", ack, 2'b01);
    checkOutput("s1_vref_ready", vref_ready, 1'b1);
    tick();
    checkOutput("s1_ack_clear", ack, 2'b00);
    checkOutput("s1_busy_clear", busy, 1'b0);
    checkOutput("s1_vref_ready_hold", vref_ready, 1'b1);

    $display("[TB] repeat of the same request, no settle");
    applyStimulus(1'b1, 1'b1, 2'b01, 5'h0A, 5'h00, 2'b01);
    period = 0;
    tick();
    checkOutput("s2_p1_vref_ready", vref_ready, 1'b0);
    checkOutput("s2_p1_hld", hld_h_n, 1'b1);
    applyStimulus(1'b1, 1'b1, 2'b00, 5'h0A, 5'h00, 2'b01);
    wait_ack(2'b11, 20, at);
    checkOutput("s2_ack_period", at, 5);
    checkOutput("s2_vref_ready", vref_ready, 1'b1);
    tick();
    checkOutput("s2_ack_clear", ack, 2'b00);

    $display("[TB] simultaneous requests after reset");
    applyStimulus(1'b0, 1'b1, 2'b00, 5'h00, 5'h00, 2'b00);
    tick();
    applyStimulus(1'b1, 1'b1, 2'b11, 5'h03, 5'h11, 2'b11);
    period = 0;
    tick();
    checkOutput("s3_first_ref_sel", ref_sel, 5'h03);
    wait_ack(2'b11, 1300, at);
    checkOutput("s3_ack0_period", at, 1205);
    checkOutput("s3_ack0_val", ack, 2'b01);
    applyStimulus(1'b1, 1'b1, 2'b10, 5'h03, 5'h11, 2'b11);
    wait_ack(2'b11, 1400, at);
    checkOutput("s3_ack1_period", at, 2411);
    checkOutput("s3_ack1_val", ack, 2'b10);
    checkOutput("s3_second_ref_sel", ref_sel, 5'h11);
    checkOutput("s3_vref_ready", vref_ready, 1'b1);
    applyStimulus(1'b1, 1'b1, 2'b00, 5'h03, 5'h11, 2'b11);
    tick();

    $display("[TB] enable_h lost during settle, then retried");
    applyStimulus(1'b1, 1'b1, 2'b01, 5'h07, 5'h00, 2'b01);
    period = 0;
    tick();
    for (int i = 0; i < 9; i++) tick();
    checkOutput("s4_p10_busy", busy, 1'b1);
    checkOutput("s4_p10_hld", hld_h_n, 1'b0);
    applyStimulus(1'b1, 1'b0, 2'b01, 5'h07, 5'h00, 2'b01);
    tick();
    checkOutput("s4_abort_err", err, 1'b1);
    checkOutput("s4_abort_hld", hld_h_n, 1'b0);
    checkOutput("s4_abort_vref_ready", vref_ready, 1'b0);
    checkOutput("s4_abort_busy", busy, 1'b0);
    checkOutput("s4_abort_ack", ack, 2'b00);
    tick();
    checkOutput("s4_err_clear", err, 1'b0);
    checkOutput("s4_no_grant_busy", busy, 1'b0);
    checkOutput("s4_no_grant_ack", ack, 2'b00);
    applyStimulus(1'b1, 1'b1, 2'b01, 5'h07, 5'h00, 2'b01);
    period = 0;
    tick();
    checkOutput("s4_retry_busy", busy, 1'b1);
    checkOutput("s4_retry_hld", hld_h_n, 1'b1);
    wait_ack(2'b11, 1300, at);
    checkOutput("s4_retry_ack_period", at, 1205);
    checkOutput("s4_retry_ack_val", ack, 2'b01);
    checkOutput("s4_retry_vref_ready", vref_ready, 1'b1);
    applyStimulus(1'b1, 1'b1, 2'b00, 5'h07, 5'h00, 2'b01);
    tick();

    $display("[TB] reset during open");
    applyStimulus(1'b1, 1'b1, 2'b01, 5'h07, 5'h00, 2'b01);
    period = 0;
    tick();
    checkOutput("s5_open_busy", busy, 1'b1);
    applyStimulus(1'b0, 1'b1, 2'b00, 5'h07, 5'h00, 2'b01);
    tick();
    checkOutput("s5_hld", hld_h_n, 1'b0);
    checkOutput("s5_ref_sel", ref_sel, 5'h00);
    checkOutput("s5_vrefgen_en", vrefgen_en, 1'b0);
    checkOutput("s5_busy", busy, 1'b0);
    checkOutput("s5_vref_ready", vref_ready, 1'b0);
    checkOutput("s5_ack", ack, 2'b00);
    checkOutput("s5_err", err, 1'b0);
    applyStimulus(1'b1, 1'b1, 2'b00, 5'h07, 5'h00, 2'b01);
    tick();
    checkOutput("s5_post_ack", ack, 2'b00);
    checkOutput("s5_post_err", err, 1'b0);
    checkOutput("s5_post_busy", busy, 1'b0);

    $display("[TB] request with generator disabled");
    applyStimulus(1'b1, 1'b1, 2'b01, 5'h15, 5'h00, 2'b00);
    period = 0;
    tick();
    checkOutput("s6_vrefgen_en", vrefgen_en, 1'b0);
    checkOutput("s6_ref_sel", ref_sel, 5'h15);
    checkOutput("s6_hld", hld_h_n, 1'b1);
    applyStimulus(1'b1, 1'b1, 2'b00, 5'h15, 5'h00, 2'b00);
    wait_ack(2'b11, 20, at);
    checkOutput("s6_ack_period", at, 5);
    checkOutput("s6_ack_val", ack, 2'b01);
    checkOutput("s6_vref_ready", vref_ready, 1'b0);
    checkOutput("s6_vrefgen_en_done", vrefgen_en, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
